// File: rtl/pps_pulse_analyzer.sv
// Measures a PPS-derived pulse train against raw PPS: phase and width in us, and the period
// in PPS edges, reported in the same encoding the PPS divider takes as configuration.
module pps_pulse_analyzer #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLKS_PER_US = 10,
  parameter int TIMEOUT_PPS = 16
) (
  input  logic                    i_clk_10,
  input  logic                    i_rst,
  input  logic                    i_pps_raw,
  input  logic                    i_pulse_raw,
  input  logic                    i_arm,
  output logic [3*DATA_WIDTH-1:0] o_phase_us,
  output logic [DATA_WIDTH-1:0]   o_width_us,
  output logic [DATA_WIDTH-1:0]   o_div_number,
  output logic                    o_overflow,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int PW  = 3 * DATA_WIDTH;
  localparam int PSW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PSW-1:0]        PS_LAST    = PSW'(CLKS_PER_US - 1);
  // The clearing cycle itself counts as elapsed, so results are floor(cycles/CLKS_PER_US).
  localparam logic [PSW-1:0]        PS_RESTART = PSW'((CLKS_PER_US > 1) ? 1 : 0);
  localparam logic [DATA_WIDTH-1:0] PPS_LIMIT  = DATA_WIDTH'(TIMEOUT_PPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PPS,
    S_PHASE,
    S_WIDTH,
    S_PERIOD
  } state_t;

  function automatic logic [PW-1:0] sat_inc_phase(input logic [PW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_inc_reg(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                  state_q, state_d;
  logic [1:0]              pps_sh_q, pls_sh_q;
  logic [PSW-1:0]          presc_q, presc_d;
  logic [PW-1:0]           phase_cnt_q, phase_cnt_d;
  logic [DATA_WIDTH-1:0]   width_cnt_q, width_cnt_d;
  logic [DATA_WIDTH-1:0]   pps_cnt_q, pps_cnt_d;
  logic [PW-1:0]           phase_lat_q, phase_lat_d;
  logic [DATA_WIDTH-1:0]   width_lat_q, width_lat_d;
  logic                    ovf_q, ovf_d;
  logic [PW-1:0]           phase_out_q;
  logic [DATA_WIDTH-1:0]   width_out_q, div_out_q;
  logic                    ovf_out_q, valid_q;

  logic                    pps_rise, pls_rise, pls_fall, tick;
  logic                    clr, publish;
  logic [DATA_WIDTH-1:0]   pps_next, div_pub;

  assign pps_rise = (pps_sh_q == 2'b01);
  assign pls_rise = (pls_sh_q == 2'b01);
  assign pls_fall = (pls_sh_q == 2'b10);
  assign tick     = (presc_q == PS_LAST);

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    width_cnt_d = width_cnt_q;
    pps_cnt_d   = pps_cnt_q;
    phase_lat_d = phase_lat_q;
    width_lat_d = width_lat_q;
    ovf_d       = ovf_q;
    clr         = 1'b0;
    publish     = 1'b0;
    div_pub     = '0;
    pps_next    = pps_rise ? sat_inc_reg(pps_cnt_q) : pps_cnt_q;

    // Phase keeps running through WIDTH/PERIOD so the next pulse's phase is ready at its rise.
    if (tick && (state_q == S_PHASE || state_q == S_WIDTH || state_q == S_PERIOD)) begin
      phase_cnt_d = sat_inc_phase(phase_cnt_q);
      if (&phase_cnt_q) ovf_d = 1'b1;
    end
    if (tick && state_q == S_WIDTH) begin
      width_cnt_d = sat_inc_reg(width_cnt_q);
      if (&width_cnt_q) ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_arm) state_d = S_WAIT_PPS;
      end
      S_WAIT_PPS: begin
        if (pps_rise) begin
          state_d     = S_PHASE;
          phase_cnt_d = '0;
          ovf_d       = 1'b0;
          clr         = 1'b1;
        end
      end
      S_PHASE: begin
        if (pls_rise) begin
          state_d     = S_WIDTH;
          phase_lat_d = pps_rise ? '0 : phase_cnt_q;
          width_cnt_d = '0;
          clr         = 1'b1;
          if (pps_rise) phase_cnt_d = '0;
        end else if (pps_rise) begin
          phase_cnt_d = '0;
          clr         = 1'b1;
        end
      end
      S_WIDTH: begin
        if (pls_fall) begin
          state_d     = S_PERIOD;
          width_lat_d = width_cnt_q;
          pps_cnt_d   = '0;
          phase_cnt_d = '0;
          clr         = 1'b1;
        end else if (pps_rise) begin
          phase_cnt_d = '0;
          clr         = 1'b1;
        end
      end
      S_PERIOD: begin
        if (pps_rise) begin
          pps_cnt_d   = pps_next;
          phase_cnt_d = '0;
          clr         = 1'b1;
          if (&pps_cnt_q) ovf_d = 1'b1;
        end
        if (pls_rise) begin
          publish     = 1'b1;
          div_pub     = pps_next;
          state_d     = S_WIDTH;
          phase_lat_d = pps_rise ? '0 : phase_cnt_q;
          width_cnt_d = '0;
          clr         = 1'b1;
        end else if (pps_next >= PPS_LIMIT) begin
          publish     = 1'b1;
          state_d     = S_WAIT_PPS;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_arm) begin
      state_d = S_IDLE;
      publish = 1'b0;
    end
    if (publish) ovf_d = 1'b0;

    if (clr)       presc_d = PS_RESTART;
    else if (tick) presc_d = '0;
    else           presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      pps_sh_q    <= '0;
      pls_sh_q    <= '0;
      presc_q     <= '0;
      phase_cnt_q <= '0;
      width_cnt_q <= '0;
      pps_cnt_q   <= '0;
      phase_lat_q <= '0;
      width_lat_q <= '0;
      ovf_q       <= 1'b0;
      phase_out_q <= '0;
      width_out_q <= '0;
      div_out_q   <= '0;
      ovf_out_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pps_sh_q    <= {pps_sh_q[0], i_pps_raw};
      pls_sh_q    <= {pls_sh_q[0], i_pulse_raw};
      presc_q     <= presc_d;
      phase_cnt_q <= phase_cnt_d;
      width_cnt_q <= width_cnt_d;
      pps_cnt_q   <= pps_cnt_d;
      phase_lat_q <= phase_lat_d;
      width_lat_q <= width_lat_d;
      ovf_q       <= ovf_d;
      valid_q     <= publish;
      if (publish) begin
        phase_out_q <= phase_lat_q;
        width_out_q <= width_lat_q;
        div_out_q   <= div_pub;
        ovf_out_q   <= ovf_q;
      end
    end
  end

  assign o_phase_us   = phase_out_q;
  assign o_width_us   = width_out_q;
  assign o_div_number = div_out_q;
  assign o_overflow   = ovf_out_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pps_pulse_analyzer.sv
// Directed bench for pps_pulse_analyzer: sim-scaled PPS frames of 200 cycles (20 us),
// hand-computed phase/width/div results for each scenario.
`timescale 1ns/1ps
module tb_pps_pulse_analyzer;

  localparam int DW    = 8;
  localparam int FRAME = 200;

  logic            clk = 1'b0;
  logic            rst, pps, pls, arm;
  logic [3*DW-1:0] o_phase_us;
  logic [DW-1:0]   o_width_us, o_div_number;
  logic            o_overflow, o_valid, o_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcnt     = 0;
  logic prev_v   = 1'b0;
  logic consec   = 1'b0;

  always #50 clk = ~clk;

  pps_pulse_analyzer #(.DATA_WIDTH(DW), .CLKS_PER_US(10), .TIMEOUT_PPS(3)) dut (
    .i_clk_10    (clk),
    .i_rst       (rst),
    .i_pps_raw   (pps),
    .i_pulse_raw (pls),
    .i_arm       (arm),
    .o_phase_us  (o_phase_us),
    .o_width_us  (o_width_us),
    .o_div_number(o_div_number),
    .o_overflow  (o_overflow),
    .o_valid     (o_valid),
    .o_busy      (o_busy)
  );

  always @(negedge clk) begin
    if (o_valid) begin
      vcnt <= vcnt + 1;
      if (prev_v) consec <= 1'b1;
    end
    prev_v <= o_valid;
  end

  task automatic step(input logic p, input logic q);
    pps = p;
    pls = q;
    @(posedge clk);
    #1;
  endtask

  // PPS high for the first 10 cycles of every frame; pulse of width w starting off cycles
  // into frame 'first', repeating every per frames.
  task automatic frames(input int n, input int per, input int off, input int w, input int first);
    int   base;
    logic ph;
    base = first * FRAME + off;
    for (int t = 0; t < n * FRAME; t++) begin
      ph = 1'b0;
      if (t >= base) ph = (((t - base) % (per * FRAME)) < w);
      step((t % FRAME) < 10, ph);
    end
  endtask

  task automatic rearm();
    arm = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    arm = 1'b1;
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; pps = 1'b0; pls = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_phase_us !== 24'd0) begin n_fail++; $display("FAIL reset_phase got %0d want 0", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd0) begin n_fail++; $display("FAIL reset_width got %0d want 0", o_width_us); end
    n_checks++; if (o_div_number !== 8'd0) begin n_fail++; $display("FAIL reset_div got %0d want 0", o_div_number); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_divider_train();
    int v0;
    rearm();
    v0 = vcnt;
    frames(7, 2, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL train_valids got %0d want 3", vcnt - v0); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL train_phase got %0d want 5", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd3) begin n_fail++; $display("FAIL train_width got %0d want 3", o_width_us); end
    n_checks++; if (o_div_number !== 8'd2) begin n_fail++; $display("FAIL train_div got %0d want 2", o_div_number); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL train_ovf got %b want 0", o_overflow); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL train_busy got %b want 1", o_busy); end
  endtask

  task automatic test_same_cycle();
    int v0;
    rearm();
    v0 = vcnt;
    frames(5, 1, 0, 10, 0);
    n_checks++; if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL same_valids got %0d want 3", vcnt - v0); end
    n_checks++; if (o_phase_us !== 24'd0) begin n_fail++; $display("FAIL same_phase got %0d want 0", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd1) begin n_fail++; $display("FAIL same_width got %0d want 1", o_width_us); end
    n_checks++; if (o_div_number !== 8'd1) begin n_fail++; $display("FAIL same_div got %0d want 1", o_div_number); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL same_ovf got %b want 0", o_overflow); end
  endtask

  task automatic test_timeout();
    int v0;
    rearm();
    v0 = vcnt;
    frames(3, 100, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL tmo_early got %0d want 0", vcnt - v0); end
    frames(1, 100, 50, 30, 100);
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL tmo_valids got %0d want 1", vcnt - v0); end
    n_checks++; if (o_div_number !== 8'd0) begin n_fail++; $display("FAIL tmo_div got %0d want 0", o_div_number); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL tmo_phase got %0d want 5", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd3) begin n_fail++; $display("FAIL tmo_width got %0d want 3", o_width_us); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL tmo_ovf got %b want 0", o_overflow); end
    // Back in WAIT_PPS: the next pulse starts a fresh measurement rather than publishing.
    frames(1, 1, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL tmo_restart got %0d want 1", vcnt - v0); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy got %b want 1", o_busy); end
  endtask

  task automatic test_overflow();
    int v0;
    rearm();
    v0 = vcnt;
    frames(16, 100, 50, 3000, 0);
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL ovf_early got %0d want 0", vcnt - v0); end
    frames(1, 1, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL ovf_valids got %0d want 1", vcnt - v0); end
    n_checks++; if (o_width_us !== 8'd255) begin n_fail++; $display("FAIL ovf_width got %0d want 255", o_width_us); end
    n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o_overflow); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL ovf_phase got %0d want 5", o_phase_us); end
    n_checks++; if (o_div_number !== 8'd1) begin n_fail++; $display("FAIL ovf_div got %0d want 1", o_div_number); end
    frames(1, 1, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL clean_valids got %0d want 2", vcnt - v0); end
    n_checks++; if (o_width_us !== 8'd3) begin n_fail++; $display("FAIL clean_width got %0d want 3", o_width_us); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clean_flag got %b want 0", o_overflow); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL clean_phase got %0d want 5", o_phase_us); end
    n_checks++; if (o_div_number !== 8'd1) begin n_fail++; $display("FAIL clean_div got %0d want 1", o_div_number); end
  endtask

  task automatic test_reset_mid_width();
    int v0;
    rearm();
    repeat (10) step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b1);
    @(posedge clk);
    #20;
    rst = 1'b1;
    #1;
    n_checks++; if (o_phase_us !== 24'd0) begin n_fail++; $display("FAIL rstw_phase got %0d want 0", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd0) begin n_fail++; $display("FAIL rstw_width got %0d want 0", o_width_us); end
    n_checks++; if (o_div_number !== 8'd0) begin n_fail++; $display("FAIL rstw_div got %0d want 0", o_div_number); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rstw_ovf got %b want 0", o_overflow); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid got %b want 0", o_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy got %b want 0", o_busy); end
    repeat (3) step(1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) step(1'b0, 1'b0);
    v0 = vcnt;
    frames(2, 2, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL rstw_early got %0d want 0", vcnt - v0); end
    n_checks++; if (o_width_us !== 8'd0) begin n_fail++; $display("FAIL rstw_hold got %0d want 0", o_width_us); end
    frames(1, 1, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rstw_valids got %0d want 1", vcnt - v0); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL rstw_phase2 got %0d want 5", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd3) begin n_fail++; $display("FAIL rstw_width2 got %0d want 3", o_width_us); end
    n_checks++; if (o_div_number !== 8'd2) begin n_fail++; $display("FAIL rstw_div2 got %0d want 2", o_div_number); end
  endtask

  task automatic test_disarm_mid_period();
    int v0;
    arm = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    arm = 1'b1;
    repeat (5) step(1'b0, 1'b1);
    v0 = vcnt;
    repeat (10)  step(1'b1, 1'b1);
    repeat (20)  step(1'b0, 1'b1);
    repeat (20)  step(1'b0, 1'b0);
    repeat (30)  step(1'b0, 1'b1);
    repeat (100) step(1'b0, 1'b0);
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL disarm_busy_before got %b want 1", o_busy); end
    arm = 1'b0;
    step(1'b0, 1'b0);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL disarm_busy got %b want 0", o_busy); end
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL disarm_valids got %0d want 0", vcnt - v0); end
    n_checks++; if (o_phase_us !== 24'd5) begin n_fail++; $display("FAIL disarm_phase got %0d want 5", o_phase_us); end
    n_checks++; if (o_width_us !== 8'd3) begin n_fail++; $display("FAIL disarm_width got %0d want 3", o_width_us); end
    n_checks++; if (o_div_number !== 8'd2) begin n_fail++; $display("FAIL disarm_div got %0d want 2", o_div_number); end
    frames(1, 1, 50, 30, 0);
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL disarm_idle got %0d want 0", vcnt - v0); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL disarm_idle_busy got %b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    n_checks++; if (consec !== 1'b0) begin n_fail++; $display("FAIL valid_consecutive got %b want 0", consec); end
  endtask

  initial begin
    test_reset();
    test_divider_train();
    test_same_cycle();
    test_timeout();
    test_overflow();
    test_reset_mid_width();
    test_disarm_mid_period();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
